// File: rtl/wbck_arbiter.sv
// Write-back arbiter: merges ALU and LSU results into one register-file write port,
// tracks outstanding loads per register and flags read hazards. Define WBCK_RR_ARB_EN for round-robin arbitration.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module wbck_arbiter #(
    parameter int unsigned XLEN        = `XLEN,
    parameter int unsigned RFIDX_WIDTH = `RFIDX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_wb_valid,
    output logic                   alu_wb_ready,
    input  logic [RFIDX_WIDTH-1:0] alu_wb_idx,
    input  logic [XLEN-1:0]        alu_wb_dat,
    input  logic                   lsu_wb_valid,
    output logic                   lsu_wb_ready,
    input  logic [RFIDX_WIDTH-1:0] lsu_wb_idx,
    input  logic [XLEN-1:0]        lsu_wb_dat,
    input  logic                   ld_issue,
    input  logic [RFIDX_WIDTH-1:0] ld_issue_idx,
    input  logic [RFIDX_WIDTH-1:0] read_src1_idx,
    input  logic [RFIDX_WIDTH-1:0] read_src2_idx,
    output logic                   src1_hazard,
    output logic                   src2_hazard,
    output logic                   wbck_dest_wen,
    output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
    output logic [XLEN-1:0]        wbck_dest_dat
);

    localparam int unsigned NREG = 1 << RFIDX_WIDTH;
    localparam logic [RFIDX_WIDTH-1:0] IDX0 = '0;

    logic [NREG-1:0]        pending_q, pending_d;
    logic                   wen_q, wen_d;
    logic [RFIDX_WIDTH-1:0] idx_q, idx_d;
    logic [XLEN-1:0]        dat_q, dat_d;
    logic                   alu_eligible;
    logic                   alu_ready_c, lsu_ready_c;

    // An ALU write must not overtake an outstanding load to the same register.
    assign alu_eligible = alu_wb_valid & ~((alu_wb_idx != IDX0) & pending_q[alu_wb_idx]);

`ifdef WBCK_RR_ARB_EN
    typedef enum logic {RR_LAST_ALU, RR_LAST_LSU} rr_e;
    rr_e rr_q, rr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= RR_LAST_ALU;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_comb begin
        lsu_ready_c = 1'b0;
        alu_ready_c = 1'b0;
        rr_d        = rr_q;
        if (!rst) begin
            if (lsu_wb_valid && alu_eligible) begin
                lsu_ready_c = (rr_q == RR_LAST_ALU);
                alu_ready_c = (rr_q == RR_LAST_LSU);
            end else begin
                lsu_ready_c = lsu_wb_valid;
                alu_ready_c = alu_eligible;
            end
            if (lsu_ready_c) begin
                rr_d = RR_LAST_LSU;
            end else if (alu_ready_c) begin
                rr_d = RR_LAST_ALU;
            end
        end
    end
`else
    always_comb begin
        lsu_ready_c = lsu_wb_valid & ~rst;
        alu_ready_c = alu_eligible & ~lsu_wb_valid & ~rst;
    end
`endif

    assign alu_wb_ready = alu_ready_c;
    assign lsu_wb_ready = lsu_ready_c;

    // Write-back capture and scoreboard update; a same-cycle load issue wins over the clear.
    always_comb begin
        wen_d     = 1'b0;
        idx_d     = idx_q;
        dat_d     = dat_q;
        pending_d = pending_q;
        if (lsu_ready_c) begin
            wen_d                 = (lsu_wb_idx != IDX0);
            idx_d                 = lsu_wb_idx;
            dat_d                 = lsu_wb_dat;
            pending_d[lsu_wb_idx] = 1'b0;
        end else if (alu_ready_c) begin
            wen_d = (alu_wb_idx != IDX0);
            idx_d = alu_wb_idx;
            dat_d = alu_wb_dat;
        end
        if (ld_issue) begin
            pending_d[ld_issue_idx] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            wen_q     <= 1'b0;
            idx_q     <= '0;
            dat_q     <= '0;
        end else begin
            pending_q <= pending_d;
            wen_q     <= wen_d;
            idx_q     <= idx_d;
            dat_q     <= dat_d;
        end
    end

    assign src1_hazard = (read_src1_idx != IDX0) &
                         (pending_q[read_src1_idx] | (wen_q & (idx_q == read_src1_idx)));
    assign src2_hazard = (read_src2_idx != IDX0) &
                         (pending_q[read_src2_idx] | (wen_q & (idx_q == read_src2_idx)));

    assign wbck_dest_wen = wen_q;
    assign wbck_dest_idx = idx_q;
    assign wbck_dest_dat = dat_q;

endmodule

// File: tb/tb_wbck_arbiter.sv
// Randomized and directed bench for wbck_arbiter against a cycle-level reference model.
`timescale 1ns/1ps
module tb_wbck_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
    logic [4:0]  alu_wb_idx, lsu_wb_idx, ld_issue_idx, read_src1_idx, read_src2_idx, wbck_dest_idx;
    logic [31:0] alu_wb_dat, lsu_wb_dat, wbck_dest_dat;
    logic        ld_issue, src1_hazard, src2_hazard, wbck_dest_wen;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: outstanding loads, last write-back, last arbitration winner.
    bit        m_pend [32];
    bit        m_wen = 1'b0;
    bit [4:0]  m_idx = '0;
    bit [31:0] m_dat = '0;
`ifdef WBCK_RR_ARB_EN
    bit        m_last_lsu = 1'b0;
`endif

    always #5 clk = ~clk;

    wbck_arbiter #(.XLEN(32), .RFIDX_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
        .alu_wb_idx(alu_wb_idx), .alu_wb_dat(alu_wb_dat),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_idx(lsu_wb_idx), .lsu_wb_dat(lsu_wb_dat),
        .ld_issue(ld_issue), .ld_issue_idx(ld_issue_idx),
        .read_src1_idx(read_src1_idx), .read_src2_idx(read_src2_idx),
        .src1_hazard(src1_hazard), .src2_hazard(src2_hazard),
        .wbck_dest_wen(wbck_dest_wen), .wbck_dest_idx(wbck_dest_idx),
        .wbck_dest_dat(wbck_dest_dat)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit haz(input logic [4:0] i);
        return (i != 0) && (m_pend[i] || (m_wen && m_idx == i));
    endfunction

    // Check every output against the model, then advance one clock.
    task automatic cyc();
        bit alu_ok, e_alu, e_lsu;
        #1;
        alu_ok = alu_wb_valid && !(alu_wb_idx != 0 && m_pend[alu_wb_idx]);
`ifdef WBCK_RR_ARB_EN
        if (lsu_wb_valid && alu_ok) begin
            e_lsu = !m_last_lsu;
            e_alu = m_last_lsu;
        end else begin
            e_lsu = lsu_wb_valid;
            e_alu = alu_ok;
        end
`else
        e_lsu = lsu_wb_valid;
        e_alu = alu_ok && !lsu_wb_valid;
`endif
        if (rst) begin
            e_lsu = 1'b0;
            e_alu = 1'b0;
        end
        check("alu_ready", alu_wb_ready, e_alu);
        check("lsu_ready", lsu_wb_ready, e_lsu);
        check("src1_hazard", src1_hazard, haz(read_src1_idx));
        check("src2_hazard", src2_hazard, haz(read_src2_idx));
        check("wen", wbck_dest_wen, m_wen);
        check("wb_idx", wbck_dest_idx, m_idx);
        check("wb_dat", wbck_dest_dat, m_dat);
        @(posedge clk);
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_wen = 1'b0;
            m_idx = '0;
            m_dat = '0;
`ifdef WBCK_RR_ARB_EN
            m_last_lsu = 1'b0;
`endif
        end else begin
            m_wen = 1'b0;
            if (e_lsu) begin
                m_wen = (lsu_wb_idx != 0);
                m_idx = lsu_wb_idx;
                m_dat = lsu_wb_dat;
                m_pend[lsu_wb_idx] = 1'b0;
`ifdef WBCK_RR_ARB_EN
                m_last_lsu = 1'b1;
`endif
            end else if (e_alu) begin
                m_wen = (alu_wb_idx != 0);
                m_idx = alu_wb_idx;
                m_dat = alu_wb_dat;
`ifdef WBCK_RR_ARB_EN
                m_last_lsu = 1'b0;
`endif
            end
            if (ld_issue && ld_issue_idx != 0) m_pend[ld_issue_idx] = 1'b1;
        end
        #2;
    endtask

    task automatic idle_inputs();
        alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0; ld_issue = 1'b0;
        alu_wb_idx = '0; lsu_wb_idx = '0; ld_issue_idx = '0;
        alu_wb_dat = '0; lsu_wb_dat = '0;
        read_src1_idx = '0; read_src2_idx = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    bit exp_lsu_seq [3];
    bit exp_alu_seq [3];

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #2;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        do_reset();
        #1;
        check("rst_wen", wbck_dest_wen, 1'b0);
        check("rst_dat", wbck_dest_dat, 32'h0);

        // Lone ALU result appears one cycle later for exactly one cycle.
        alu_wb_valid = 1'b1; alu_wb_idx = 5'd5; alu_wb_dat = 32'h12345678;
        #1 check("alu_alone_rdy", alu_wb_ready, 1'b1);
        cyc();
        alu_wb_valid = 1'b0;
        #1;
        check("alu_alone_wen", wbck_dest_wen, 1'b1);
        check("alu_alone_idx", wbck_dest_idx, 5'd5);
        check("alu_alone_dat", wbck_dest_dat, 32'h12345678);
        cyc();
        #1 check("alu_alone_wen_drop", wbck_dest_wen, 1'b0);

        // Load hazard lifecycle on x7.
        ld_issue = 1'b1; ld_issue_idx = 5'd7;
        cyc();
        ld_issue = 1'b0; read_src1_idx = 5'd7;
        #1 check("ld_haz_set", src1_hazard, 1'b1);
        cyc();
        cyc();
        lsu_wb_valid = 1'b1; lsu_wb_idx = 5'd7; lsu_wb_dat = 32'hDEADBEEF;
        #1 check("ld_lsu_rdy", lsu_wb_ready, 1'b1);
        cyc();
        lsu_wb_valid = 1'b0;
        #1;
        check("ld_haz_wen_cycle", src1_hazard, 1'b1);
        check("ld_wb_dat", wbck_dest_dat, 32'hDEADBEEF);
        cyc();
        #1 check("ld_haz_clear", src1_hazard, 1'b0);
        read_src1_idx = '0;

        // Contention for three cycles from a fresh reset.
        do_reset();
`ifdef WBCK_RR_ARB_EN
        exp_lsu_seq = '{1'b1, 1'b0, 1'b1};
        exp_alu_seq = '{1'b0, 1'b1, 1'b0};
`else
        exp_lsu_seq = '{1'b1, 1'b1, 1'b1};
        exp_alu_seq = '{1'b0, 1'b0, 1'b0};
`endif
        alu_wb_valid = 1'b1; alu_wb_idx = 5'd2; alu_wb_dat = 32'hA1;
        lsu_wb_valid = 1'b1; lsu_wb_idx = 5'd4; lsu_wb_dat = 32'hB1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("cont_lsu_rdy", lsu_wb_ready, exp_lsu_seq[k]);
            check("cont_alu_rdy", alu_wb_ready, exp_alu_seq[k]);
            cyc();
        end
        idle_inputs();

        // WAW: ALU to x9 waits for the outstanding load to x9.
        ld_issue = 1'b1; ld_issue_idx = 5'd9;
        cyc();
        ld_issue = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_idx = 5'd9; alu_wb_dat = 32'h0000000A;
        #1 check("waw_alu_blocked", alu_wb_ready, 1'b0);
        cyc();
        cyc();
        lsu_wb_valid = 1'b1; lsu_wb_idx = 5'd9; lsu_wb_dat = 32'h0000000B;
        #1;
        check("waw_lsu_rdy", lsu_wb_ready, 1'b1);
        check("waw_alu_still_blocked", alu_wb_ready, 1'b0);
        cyc();
        lsu_wb_valid = 1'b0;
        #1;
        check("waw_alu_rdy", alu_wb_ready, 1'b1);
        check("waw_load_first", wbck_dest_dat, 32'h0000000B);
        cyc();
        alu_wb_valid = 1'b0;
        #1 check("waw_alu_second", wbck_dest_dat, 32'h0000000A);
        cyc();

        // Register 0: accepted, never written, never hazardous.
        alu_wb_valid = 1'b1; alu_wb_idx = 5'd0; alu_wb_dat = 32'hFFFFFFFF;
        ld_issue = 1'b1; ld_issue_idx = 5'd0; read_src2_idx = 5'd0;
        #1 check("x0_rdy", alu_wb_ready, 1'b1);
        cyc();
        idle_inputs();
        #1;
        check("x0_wen", wbck_dest_wen, 1'b0);
        check("x0_dat", wbck_dest_dat, 32'hFFFFFFFF);
        check("x0_haz", src2_hazard, 1'b0);
        cyc();

        // Reset with a pending load and both sources offering.
        ld_issue = 1'b1; ld_issue_idx = 5'd3;
        cyc();
        ld_issue = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_idx = 5'd1; alu_wb_dat = 32'h11;
        lsu_wb_valid = 1'b1; lsu_wb_idx = 5'd3; lsu_wb_dat = 32'h33;
        rst = 1'b1;
        #1;
        check("rst_alu_rdy", alu_wb_ready, 1'b0);
        check("rst_lsu_rdy", lsu_wb_ready, 1'b0);
        cyc();
        rst = 1'b0;
        idle_inputs();
        read_src1_idx = 5'd3;
        #1;
        check("post_rst_haz", src1_hazard, 1'b0);
        check("post_rst_wen", wbck_dest_wen, 1'b0);
        cyc();

        // Random traffic on a narrow register range to force collisions.
        for (int n = 0; n < 2500; n++) begin
            rst           = ($urandom_range(99) == 0);
            alu_wb_valid  = $urandom_range(1);
            alu_wb_idx    = 5'($urandom_range(7));
            alu_wb_dat    = $urandom;
            lsu_wb_valid  = $urandom_range(1);
            lsu_wb_idx    = 5'($urandom_range(7));
            lsu_wb_dat    = $urandom;
            ld_issue      = ($urandom_range(3) == 0);
            ld_issue_idx  = 5'($urandom_range(7));
            read_src1_idx = 5'($urandom_range(7));
            read_src2_idx = 5'($urandom_range(7));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
